// File: rtl/node.sv
// One processing element of a systolic kd-tree of 24-bit RGB centers: it captures a center
// from the fill stream, fills its subtree, then keeps its center ordered against its children.
module node #(
  parameter string NAME = "node"
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] data_from_top,
  input  logic [23:0] data_from_left,
  input  logic [23:0] data_from_right,
  input  logic [4:0]  command_from_top,
  input  logic [4:0]  command_from_left,
  input  logic [4:0]  command_from_right,
  output logic [23:0] data_to_top,
  output logic [23:0] data_to_left,
  output logic [23:0] data_to_right,
  output logic [4:0]  command_to_top,
  output logic [4:0]  command_to_left,
  output logic [4:0]  command_to_right
);

  localparam logic [4:0] CMD_NOP       = 5'h00;
  localparam logic [4:0] CMD_FILL      = 5'h01;
  localparam logic [4:0] CMD_FILL_DONE = 5'h05;
  localparam logic [4:0] CMD_BUSY      = 5'h08;
  localparam logic [4:0] CMD_START     = 5'h09;
  localparam logic [4:0] CMD_SWITCH    = 5'h0B;
  localparam logic [4:0] CMD_VALID     = 5'h0F;
  localparam logic [4:0] CMD_DNE       = 5'h10;
  localparam logic [4:0] CMD_RST_DONE  = 5'h1E;
  localparam logic [4:0] CMD_RST       = 5'h1F;

  typedef enum logic [2:0] {S_EMPTY, S_RESETTING, S_FILLED, S_FULL, S_SORT} state_t;

  state_t      state, state_n;
  logic [23:0] center, center_n;
  logic [23:0] data_left_n, data_right_n;
  logic [1:0]  axis, axis_n;
  logic [1:0]  settle, settle_n;
  logic [4:0]  cmd_top_n, cmd_left_n, cmd_right_n;
  logic        left_absent, right_absent, left_full, right_full;
  logic        left_sorted, right_sorted, left_swap, right_swap;
  logic        left_rst_done, right_rst_done;

  // NAME only labels simulation traces; it has no hardware behind it.
  if (NAME == "") begin : g_unnamed
  end

  function automatic logic [7:0] key_of(input logic [23:0] c, input logic [1:0] ax);
    case (ax)
      2'd1:    return c[15:8];
      2'd2:    return c[7:0];
      default: return c[23:16];
    endcase
  endfunction

  function automatic logic [1:0] next_axis(input logic [1:0] ax);
    return (ax == 2'd2) ? 2'd0 : ax + 2'd1;
  endfunction

  assign data_to_top = center;

  assign left_absent    = (command_from_left == CMD_DNE);
  assign right_absent   = (command_from_right == CMD_DNE);
  assign left_full      = left_absent || (command_from_left == CMD_FILL_DONE);
  assign right_full     = right_absent || (command_from_right == CMD_FILL_DONE);
  assign left_sorted    = left_absent || (command_from_left == CMD_VALID);
  assign right_sorted   = right_absent || (command_from_right == CMD_VALID);
  assign left_swap      = !left_absent && (key_of(data_from_left, axis) > key_of(center, axis));
  assign right_swap     = !right_absent && (key_of(data_from_right, axis) < key_of(center, axis));
  // A child's rst_done only counts once our own rst has had time to reach it (settle back at 0).
  assign left_rst_done  = left_absent || (settle == 2'd0 && command_from_left == CMD_RST_DONE);
  assign right_rst_done = right_absent || (settle == 2'd0 && command_from_right == CMD_RST_DONE);

  always_comb begin
    state_n      = state;
    center_n     = center;
    axis_n       = axis;
    settle_n     = settle;
    cmd_top_n    = CMD_NOP;
    cmd_left_n   = CMD_NOP;
    cmd_right_n  = CMD_NOP;
    data_left_n  = data_to_left;
    data_right_n = data_to_right;
    if (command_from_top == CMD_RST) begin
      state_n      = S_RESETTING;
      center_n     = '0;
      axis_n       = '0;
      settle_n     = 2'd1;
      cmd_left_n   = CMD_RST;
      cmd_right_n  = CMD_RST;
      data_left_n  = '0;
      data_right_n = '0;
      if (left_absent && right_absent) cmd_top_n = CMD_RST_DONE;
    end else if (command_from_top == CMD_START) begin
      axis_n    = (data_from_top[1:0] == 2'd3) ? 2'd0 : data_from_top[1:0];
      state_n   = S_SORT;
      settle_n  = (left_absent && right_absent) ? 2'd0 : 2'd1;
      cmd_top_n = CMD_BUSY;
      if (!left_absent) begin
        cmd_left_n  = CMD_START;
        data_left_n = {22'b0, next_axis(axis_n)};
      end
      if (!right_absent) begin
        cmd_right_n  = CMD_START;
        data_right_n = {22'b0, next_axis(axis_n)};
      end
    end else begin
      case (state)
        S_EMPTY, S_RESETTING: begin
          if (state == S_RESETTING) begin
            settle_n = 2'd0;
            if (left_rst_done && right_rst_done) cmd_top_n = CMD_RST_DONE;
          end
          if (command_from_top == CMD_FILL) begin
            center_n  = data_from_top;
            state_n   = S_FILLED;
            cmd_top_n = CMD_NOP;
          end
        end
        S_FILLED: begin
          if (left_full && right_full) begin
            state_n   = S_FULL;
            cmd_top_n = CMD_FILL_DONE;
          end else if (command_from_top == CMD_FILL) begin
            if (!left_full) begin
              cmd_left_n  = CMD_FILL;
              data_left_n = data_from_top;
            end else begin
              cmd_right_n  = CMD_FILL;
              data_right_n = data_from_top;
            end
          end
        end
        S_FULL: cmd_top_n = CMD_FILL_DONE;
        S_SORT: begin
          cmd_top_n = CMD_BUSY;
          // A switch from above must not cut short the wait after our own swap.
          if (command_from_top == CMD_SWITCH) begin
            center_n = data_from_top;
            settle_n = (settle == 2'd0) ? 2'd0 : settle - 2'd1;
          end else if (settle != 2'd0) begin
            settle_n = settle - 2'd1;
          end else if (left_swap) begin
            center_n    = data_from_left;
            cmd_left_n  = CMD_SWITCH;
            data_left_n = center;
            settle_n    = 2'd2;
          end else if (right_swap) begin
            center_n     = data_from_right;
            cmd_right_n  = CMD_SWITCH;
            data_right_n = center;
            settle_n     = 2'd2;
          end else if (left_sorted && right_sorted) begin
            cmd_top_n = CMD_VALID;
          end
        end
        default: state_n = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= S_EMPTY;
      center           <= '0;
      axis             <= '0;
      settle           <= '0;
      command_to_top   <= CMD_NOP;
      command_to_left  <= CMD_NOP;
      command_to_right <= CMD_NOP;
      data_to_left     <= '0;
      data_to_right    <= '0;
    end else begin
      state            <= state_n;
      center           <= center_n;
      axis             <= axis_n;
      settle           <= settle_n;
      command_to_top   <= cmd_top_n;
      command_to_left  <= cmd_left_n;
      command_to_right <= cmd_right_n;
      data_to_left     <= data_left_n;
      data_to_right    <= data_right_n;
    end
  end

endmodule

// File: tb/tb_node.sv
// Bench for node: a 7-node tree, a 3-node tree and a lone leaf, each driven by its own
// controller port and checked against orderings and fill rules computed here.
module tb_node;

  localparam logic [4:0] NOP      = 5'h00;
  localparam logic [4:0] CF       = 5'h01;
  localparam logic [4:0] CF_DONE  = 5'h05;
  localparam logic [4:0] BUSY     = 5'h08;
  localparam logic [4:0] START    = 5'h09;
  localparam logic [4:0] SWITCH   = 5'h0B;
  localparam logic [4:0] VALID    = 5'h0F;
  localparam logic [4:0] DNE      = 5'h10;
  localparam logic [4:0] RST_DONE = 5'h1E;
  localparam logic [4:0] RST      = 5'h1F;

  // Nodes 0..6 form the 7-node heap, 7..9 the 3-node tree, 10 is a lone leaf.
  localparam int N = 11;
  localparam int PAR [N] = '{-1, 0, 0, 1, 1, 2, 2, -1, 7, 7, -1};
  localparam int LK  [N] = '{1, 3, 5, -1, -1, -1, -1, 8, -1, -1, -1};
  localparam int RK  [N] = '{2, 4, 6, -1, -1, -1, -1, 9, -1, -1, -1};
  localparam int CI  [N] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 2};
  localparam int TREE7 = 0;
  localparam int TREE3 = 7;
  localparam int LEAF  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] ctl_data [3];
  logic [4:0]  ctl_cmd  [3];
  wire  [23:0] dt [N];
  wire  [23:0] dl [N];
  wire  [23:0] dr [N];
  wire  [4:0]  ct [N];
  wire  [4:0]  cl [N];
  wire  [4:0]  cr [N];
  int          checks = 0;
  int          fails  = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < N; i++) begin : g_node
    wire [23:0] dft, dfl, dfr;
    wire [4:0]  cft, cfl, cfr;
    if (PAR[i] < 0) begin : g_root
      assign dft = ctl_data[CI[i]];
      assign cft = ctl_cmd[CI[i]];
    end else if (LK[PAR[i]] == i) begin : g_lchild
      assign dft = dl[PAR[i]];
      assign cft = cl[PAR[i]];
    end else begin : g_rchild
      assign dft = dr[PAR[i]];
      assign cft = cr[PAR[i]];
    end
    if (LK[i] >= 0) begin : g_left
      assign dfl = dt[LK[i]];
      assign cfl = ct[LK[i]];
    end else begin : g_noleft
      assign dfl = '0;
      assign cfl = DNE;
    end
    if (RK[i] >= 0) begin : g_right
      assign dfr = dt[RK[i]];
      assign cfr = ct[RK[i]];
    end else begin : g_noright
      assign dfr = '0;
      assign cfr = DNE;
    end
    node #(.NAME("node")) u_node (
      .clk               (clk),
      .reset             (reset),
      .data_from_top     (dft),
      .data_from_left    (dfl),
      .data_from_right   (dfr),
      .command_from_top  (cft),
      .command_from_left (cfl),
      .command_from_right(cfr),
      .data_to_top       (dt[i]),
      .data_to_left      (dl[i]),
      .data_to_right     (dr[i]),
      .command_to_top    (ct[i]),
      .command_to_left   (cl[i]),
      .command_to_right  (cr[i])
    );
  end

  function automatic logic [7:0] key8(input logic [23:0] v, input logic [1:0] ax);
    return 8'((v >> (8 * (2 - ax))) & 24'hFF);
  endfunction

  function automatic logic [71:0] sort3(input logic [23:0] x, input logic [23:0] y, input logic [23:0] z);
    logic [23:0] t;
    if (x > y) begin t = x; x = y; y = t; end
    if (y > z) begin t = y; y = z; z = t; end
    if (x > y) begin t = x; x = y; y = t; end
    return {x, y, z};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one command for exactly one clock edge, then return the port to nop.
  task automatic applyStimulus(input int port, input logic [4:0] cmd, input logic [23:0] data);
    ctl_cmd[port]  = cmd;
    ctl_data[port] = data;
    tick();
    ctl_cmd[port]  = NOP;
  endtask

  task automatic waitStatus(input string tag, input int idx, input logic [4:0] code, input int bound);
    int n;
    n = 0;
    while (ct[idx] !== code && n < bound) begin
      tick();
      n++;
    end
    checkOutput(tag, ct[idx], code);
  endtask

  task automatic checkFillSet(input string tag);
    bit          seen [64];
    bit          ok;
    logic [23:0] v;
    for (int i = 0; i < 64; i++) seen[i] = 1'b0;
    for (int i = 0; i < 7; i++) begin
      v  = dt[i];
      ok = (v >= 24'd1) && (v <= 24'd20) && !seen[v[5:0]];
      if (ok) seen[v[5:0]] = 1'b1;
      checkOutput($sformatf("%s node%0d unique stream item", tag, i), ok, 1'b1);
    end
  endtask

  task automatic loadTree3(input string tag, input logic [23:0] a, input logic [23:0] b, input logic [23:0] c);
    applyStimulus(1, RST, 24'h0);
    waitStatus({tag, " rst_done"}, TREE3, RST_DONE, 10);
    applyStimulus(1, CF, a);
    applyStimulus(1, CF, b);
    repeat (3) tick();
    applyStimulus(1, CF, c);
    waitStatus({tag, " fill_done"}, TREE3, CF_DONE, 12);
    checkOutput({tag, " loaded"}, {dt[7], dt[8], dt[9]}, {a, b, c});
  endtask

  // Expected result: children and root hold the three keys in ascending order left/root/right.
  task automatic sortRound(input string tag, input logic [23:0] a, input logic [23:0] b,
                           input logic [23:0] c, input logic [1:0] ax, input int bound);
    logic [1:0]  eff;
    logic [23:0] v [3];
    logic [23:0] t;
    eff = (ax == 2'd3) ? 2'd0 : ax;
    loadTree3(tag, a, b, c);
    applyStimulus(1, START, {22'b0, ax});
    waitStatus({tag, " valid_sort"}, TREE3, VALID, bound);
    v[0] = a;
    v[1] = b;
    v[2] = c;
    for (int p = 0; p < 2; p++)
      for (int q = 0; q < 2 - p; q++)
        if (key8(v[q], eff) > key8(v[q + 1], eff)) begin
          t = v[q]; v[q] = v[q + 1]; v[q + 1] = t;
        end
    checkOutput({tag, " left key"},  key8(dt[8], eff), key8(v[0], eff));
    checkOutput({tag, " root key"},  key8(dt[7], eff), key8(v[1], eff));
    checkOutput({tag, " right key"}, key8(dt[9], eff), key8(v[2], eff));
    checkOutput({tag, " centers conserved"}, sort3(dt[7], dt[8], dt[9]), sort3(a, b, c));
  endtask

  initial begin
    reset = 1'b1;
    for (int p = 0; p < 3; p++) begin
      ctl_cmd[p]  = NOP;
      ctl_data[p] = '0;
    end
    repeat (2) tick();
    reset = 1'b0;
    tick();
    checkOutput("leaf reset data", dt[LEAF], 24'h0);
    checkOutput("leaf reset status", ct[LEAF], NOP);
    checkOutput("tree7 reset status", ct[TREE7], NOP);

    // Lone leaf: rst, fill, sort and an incoming switch.
    applyStimulus(2, RST, 24'hFFFFFF);
    checkOutput("leaf rst_done", ct[LEAF], RST_DONE);
    checkOutput("leaf data after rst", dt[LEAF], 24'h0);
    applyStimulus(2, CF, 24'h123456);
    checkOutput("leaf filled", dt[LEAF], 24'h123456);
    tick();
    checkOutput("leaf fill_done", ct[LEAF], CF_DONE);
    applyStimulus(2, START, 24'h1);
    checkOutput("leaf busy after start", ct[LEAF], BUSY);
    tick();
    checkOutput("leaf valid after start", ct[LEAF], VALID);
    applyStimulus(2, SWITCH, 24'hABCDEF);
    checkOutput("leaf switch data", dt[LEAF], 24'hABCDEF);
    checkOutput("leaf busy after switch", ct[LEAF], BUSY);
    tick();
    checkOutput("leaf valid after switch", ct[LEAF], VALID);

    // 7-node tree: rst, fill stream, discard after full, rst again.
    applyStimulus(0, RST, 24'h0);
    waitStatus("tree7 rst_done", TREE7, RST_DONE, 8);
    for (int i = 0; i < 7; i++) checkOutput($sformatf("tree7 node%0d cleared", i), dt[i], 24'h0);
    for (int i = 1; i <= 20; i++) applyStimulus(0, CF, 24'(i));
    waitStatus("tree7 fill_done", TREE7, CF_DONE, 6);
    checkOutput("tree7 root center", dt[0], 24'h000001);
    checkOutput("tree7 left center", dt[1], 24'h000002);
    checkFillSet("tree7 fill");
    for (int i = 33; i <= 40; i++) applyStimulus(0, CF, 24'(i));
    repeat (3) tick();
    checkOutput("tree7 root after extra", dt[0], 24'h000001);
    checkOutput("tree7 left after extra", dt[1], 24'h000002);
    checkOutput("tree7 still fill_done", ct[TREE7], CF_DONE);
    checkFillSet("tree7 extra ignored");
    applyStimulus(0, RST, 24'h0);
    waitStatus("tree7 second rst_done", TREE7, RST_DONE, 8);
    for (int i = 0; i < 7; i++) checkOutput($sformatf("tree7 node%0d recleared", i), dt[i], 24'h0);

    // 3-node tree sorting: directed cases, then random ones.
    sortRound("sort directed", 24'h100000, 24'h200000, 24'h050000, 2'd0, 60);
    checkOutput("sort directed positions", {dt[8], dt[7], dt[9]}, {24'h050000, 24'h100000, 24'h200000});
    sortRound("sort equal keys", 24'h101010, 24'h10FFFF, 24'h10FFFF, 2'd0, 6);
    checkOutput("sort equal no swap", {dt[7], dt[8], dt[9]}, {24'h101010, 24'h10FFFF, 24'h10FFFF});
    for (int r = 0; r < 6; r++)
      sortRound($sformatf("sort random%0d", r), 24'($urandom), 24'($urandom), 24'($urandom),
                2'($urandom_range(0, 3)), 200);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
